// File: rtl/e203_wbck_pkg.sv
// Shared constants, payload bundle and helpers for the EXU write-back arbiter.
// Imported by e203_wbck_rr_arb and e203_exu_wbck_arb.
package e203_wbck_pkg;

    localparam int              WBCK_NCH        = 3;
    localparam int              WBCK_XLEN       = 32;
    localparam int              WBCK_RFIDX_W    = 5;
    localparam int              WBCK_FLAG_W     = 5;
    localparam logic [2:0]      WBCK_HIPRI_MASK = 3'b010;
    localparam int              WBCK_STARVE_MAX = 7;

    // Write-back payload at the default widths
    typedef struct packed {
        logic [WBCK_XLEN-1:0]    wdat;
        logic [WBCK_RFIDX_W-1:0] rdidx;
        logic                    rdfpu;
        logic [WBCK_FLAG_W-1:0]  flags;
    } wbck_pld_t;

    // Bits needed to count 0..smax
    function automatic int starve_cnt_w(input int smax);
        return $clog2(smax + 1);
    endfunction

endpackage

// File: rtl/e203_wbck_rr_arb.sv
// Masked round-robin picker: searches from rr_ptr upward with wrap,
// and moves the pointer past the winner when upd_i is set.
module e203_wbck_rr_arb
    import e203_wbck_pkg::*;
#(
    parameter int N = WBCK_NCH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] mask_i,
    input  logic         upd_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            idx;

    // First eligible requester at or after the pointer, wrapping
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[idx] && mask_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Next pointer is one past the winner
    always_comb begin
        ptr_d = ptr_q;
        if (upd_i) begin
            for (int k = 0; k < N; k++) begin
                if (grant_o[k]) ptr_d = (k == N - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// N-channel write-back arbiter: fixed-priority high class, round-robin
// low class with starvation guard, one-entry registered output stage.
// Optional FP regfile port enabled by defining E203_WBCK_FPU_EN.
module e203_exu_wbck_arb
    import e203_wbck_pkg::*;
#(
    parameter int             NCH        = WBCK_NCH,
    parameter int             XLEN       = WBCK_XLEN,
    parameter int             RFIDX_W    = WBCK_RFIDX_W,
    parameter int             FLAG_W     = WBCK_FLAG_W,
    parameter logic [NCH-1:0] HIPRI_MASK = NCH'(WBCK_HIPRI_MASK),
    parameter int             STARVE_MAX = WBCK_STARVE_MAX
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         wbck_i_valid,
    output logic [NCH-1:0]         wbck_i_ready,
    input  logic [NCH*XLEN-1:0]    wbck_i_wdat,
    input  logic [NCH*RFIDX_W-1:0] wbck_i_rdidx,
    input  logic [NCH-1:0]         wbck_i_rdfpu,
    input  logic [NCH*FLAG_W-1:0]  wbck_i_flags,
    input  logic                   rf_wbck_o_ready,
    output logic                   rf_wbck_o_ena,
    output logic [XLEN-1:0]        rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0]     rf_wbck_o_rdidx,
`ifdef E203_WBCK_FPU_EN
    input  logic                   frf_wbck_o_ready,
    output logic                   frf_wbck_o_ena,
    output logic [XLEN-1:0]        frf_wbck_o_wdat,
    output logic [RFIDX_W-1:0]     frf_wbck_o_rdidx,
    output logic [FLAG_W-1:0]      frf_wbck_o_flags,
`endif
    output logic [NCH-1:0]         wbck_o_grant
);

    localparam int             SCW  = starve_cnt_w(STARVE_MAX);
    localparam logic [SCW-1:0] SMAX = SCW'(STARVE_MAX);

    logic [NCH-1:0]     hi_m, lo_m, vld_hi;
    logic [NCH-1:0]     hi_gnt, lo_gnt, gnt;
    logic               any_hi, any_lo, hi_found;
    logic               starve_hit, lo_win, hi_win;
    logic               drain, can_load, acc;

    logic               out_vld_q, out_vld_d;
    logic [XLEN-1:0]    out_wdat_q, out_wdat_d;
    logic [RFIDX_W-1:0] out_rdidx_q, out_rdidx_d;
    logic               out_rdfpu_q, out_rdfpu_d;
    logic [NCH-1:0]     out_grant_q, out_grant_d;
    logic [SCW-1:0]     starve_q, starve_d;

    logic [XLEN-1:0]    sel_wdat;
    logic [RFIDX_W-1:0] sel_rdidx;
    logic               sel_rdfpu;

    assign hi_m   = HIPRI_MASK;
    assign lo_m   = ~HIPRI_MASK;
    assign vld_hi = wbck_i_valid & hi_m;
    assign any_hi = |vld_hi;
    assign any_lo = |(wbck_i_valid & lo_m);

    // Lowest-index valid high-class channel
    always_comb begin
        hi_gnt   = '0;
        hi_found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!hi_found && vld_hi[i]) begin
                hi_gnt[i] = 1'b1;
                hi_found  = 1'b1;
            end
        end
    end

    e203_wbck_rr_arb #(
        .N (NCH)
    ) u_lo_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (wbck_i_valid),
        .mask_i  (lo_m),
        .upd_i   (acc & lo_win),
        .grant_o (lo_gnt)
    );

    assign starve_hit = (starve_q == SMAX) & any_lo;
    assign gnt        = (any_hi & ~starve_hit) ? hi_gnt : lo_gnt;
    assign lo_win     = |(gnt & lo_m);
    assign hi_win     = |(gnt & hi_m);

`ifdef E203_WBCK_FPU_EN
    logic [FLAG_W-1:0]  out_flags_q, out_flags_d;
    logic [FLAG_W-1:0]  sel_flags;
    assign drain = out_vld_q
                 & (out_rdfpu_q ? frf_wbck_o_ready : rf_wbck_o_ready);
`else
    logic unused_flags;
    assign unused_flags = ^wbck_i_flags;
    // FP entries have no sink and leave the stage unconditionally
    assign drain = out_vld_q & (out_rdfpu_q | rf_wbck_o_ready);
`endif

    assign can_load     = ~out_vld_q | drain;
    assign wbck_i_ready = gnt & {NCH{can_load}};
    assign acc          = |wbck_i_ready;

    // Payload of the granted channel
    always_comb begin
        sel_wdat  = '0;
        sel_rdidx = '0;
        sel_rdfpu = 1'b0;
`ifdef E203_WBCK_FPU_EN
        sel_flags = '0;
`endif
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) begin
                sel_wdat  = wbck_i_wdat[i*XLEN +: XLEN];
                sel_rdidx = wbck_i_rdidx[i*RFIDX_W +: RFIDX_W];
                sel_rdfpu = wbck_i_rdfpu[i];
`ifdef E203_WBCK_FPU_EN
                sel_flags = wbck_i_flags[i*FLAG_W +: FLAG_W];
`endif
            end
        end
    end

    // Output stage and starvation counter next state
    always_comb begin
        out_vld_d   = out_vld_q;
        out_wdat_d  = out_wdat_q;
        out_rdidx_d = out_rdidx_q;
        out_rdfpu_d = out_rdfpu_q;
        out_grant_d = out_grant_q;
`ifdef E203_WBCK_FPU_EN
        out_flags_d = out_flags_q;
`endif
        starve_d    = starve_q;
        if (acc) begin
            out_vld_d   = 1'b1;
            out_wdat_d  = sel_wdat;
            out_rdidx_d = sel_rdidx;
            out_rdfpu_d = sel_rdfpu;
            out_grant_d = gnt;
`ifdef E203_WBCK_FPU_EN
            out_flags_d = sel_flags;
`endif
        end else if (drain) begin
            out_vld_d   = 1'b0;
            out_grant_d = '0;
        end
        if (can_load) begin
            if (lo_win || !any_lo) begin
                starve_d = '0;
            end else if (hi_win && starve_q != SMAX) begin
                starve_d = starve_q + SCW'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q   <= 1'b0;
            out_wdat_q  <= '0;
            out_rdidx_q <= '0;
            out_rdfpu_q <= 1'b0;
            out_grant_q <= '0;
`ifdef E203_WBCK_FPU_EN
            out_flags_q <= '0;
`endif
            starve_q    <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_wdat_q  <= out_wdat_d;
            out_rdidx_q <= out_rdidx_d;
            out_rdfpu_q <= out_rdfpu_d;
            out_grant_q <= out_grant_d;
`ifdef E203_WBCK_FPU_EN
            out_flags_q <= out_flags_d;
`endif
            starve_q    <= starve_d;
        end
    end

    assign rf_wbck_o_ena   = out_vld_q & ~out_rdfpu_q;
    assign rf_wbck_o_wdat  = out_wdat_q;
    assign rf_wbck_o_rdidx = out_rdidx_q;
    assign wbck_o_grant    = out_grant_q;

`ifdef E203_WBCK_FPU_EN
    assign frf_wbck_o_ena   = out_vld_q & out_rdfpu_q;
    assign frf_wbck_o_wdat  = out_wdat_q;
    assign frf_wbck_o_rdidx = out_rdidx_q;
    assign frf_wbck_o_flags = out_flags_q;
`endif

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Scoreboard bench for e203_exu_wbck_arb: accepted payloads are queued
// and matched against integer regfile writes; grant order is logged.
module tb_e203_exu_wbck_arb;

    localparam int NCH  = 3;
    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int FW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]     vld, rdy, fpv, grant;
    logic [XLEN-1:0]    wd [NCH];
    logic [RW-1:0]      ri [NCH];
    logic [FW-1:0]      fl [NCH];
    logic [NCH*XLEN-1:0] wd_p;
    logic [NCH*RW-1:0]   ri_p;
    logic [NCH*FW-1:0]   fl_p;
    logic               rf_rdy, rf_ena;
    logic [XLEN-1:0]    rf_wd;
    logic [RW-1:0]      rf_ri;
`ifdef E203_WBCK_FPU_EN
    logic               frf_rdy = 1'b1;
    logic               frf_ena;
    logic [XLEN-1:0]    frf_wd;
    logic [RW-1:0]      frf_ri;
    logic [FW-1:0]      frf_fl;
`endif

    logic [NCH-1:0]     keep;
    int                 seq;
    logic [XLEN+RW-1:0] sb [$];
    int                 gq [$];
    int                 checks, fails;
    logic [XLEN-1:0]    hold_a, hold_b;

    always_comb begin
        wd_p = '0;
        ri_p = '0;
        fl_p = '0;
        for (int i = 0; i < NCH; i++) begin
            wd_p[i*XLEN +: XLEN] = wd[i];
            ri_p[i*RW +: RW]     = ri[i];
            fl_p[i*FW +: FW]     = fl[i];
        end
    end

    e203_exu_wbck_arb dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wbck_i_valid    (vld),
        .wbck_i_ready    (rdy),
        .wbck_i_wdat     (wd_p),
        .wbck_i_rdidx    (ri_p),
        .wbck_i_rdfpu    (fpv),
        .wbck_i_flags    (fl_p),
        .rf_wbck_o_ready (rf_rdy),
        .rf_wbck_o_ena   (rf_ena),
        .rf_wbck_o_wdat  (rf_wd),
        .rf_wbck_o_rdidx (rf_ri),
`ifdef E203_WBCK_FPU_EN
        .frf_wbck_o_ready (frf_rdy),
        .frf_wbck_o_ena   (frf_ena),
        .frf_wbck_o_wdat  (frf_wd),
        .frf_wbck_o_rdidx (frf_ri),
        .frf_wbck_o_flags (frf_fl),
`endif
        .wbck_o_grant    (grant)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic new_pld(input int i);
        wd[i] = {8'(i), 24'(seq)};
        ri[i] = RW'(seq * 3 + i);
        seq++;
    endtask

    // Called at a negedge: latch accepts, move past posedge, update sources
    task automatic adv();
        logic [NCH-1:0] a;
        a = vld & rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (a[i]) begin
                if (keep[i]) new_pld(i);
                else         vld[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        adv();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld   = '0;
        keep  = '0;
        fpv   = '0;
        sb.delete();
        gq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic flush(input string tag);
        for (int n = 0; n < 64 && sb.size() != 0; n++) tick();
        check(tag, sb.size(), 0);
    endtask

    // Monitor: retire writes, then record this cycle's accepts
    always @(negedge clk) begin
        if (rst_n) begin
            check("rdy_onehot", $countones(rdy) <= 1, 1);
            if (rf_ena && rf_rdy) begin
                check("wb_pending", sb.size() != 0, 1);
                if (sb.size() != 0) check("wb_data", {rf_wd, rf_ri}, sb.pop_front());
            end
            for (int i = 0; i < NCH; i++) begin
                if (vld[i] && rdy[i]) begin
                    gq.push_back(i);
                    if (!fpv[i]) sb.push_back({wd[i], ri[i]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        fails  = 0;
        seq    = 1;
        vld    = '0;
        fpv    = '0;
        keep   = '0;
        rf_rdy = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            wd[i] = '0;
            ri[i] = '0;
            fl[i] = '0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ena", rf_ena, 0);
        check("rst_wdat", rf_wd, 0);
        check("rst_rdidx", rf_ri, 0);
        check("rst_grant", grant, 0);
        check("rst_ready", rdy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single low-class write
        wd[0] = 32'hDEADBEEF;
        ri[0] = 5'd5;
        vld   = 3'b001;
        @(negedge clk);
        check("a_ready", rdy, 3'b001);
        check("a_ena_pre", rf_ena, 0);
        adv();
        @(negedge clk);
        check("a_ena", rf_ena, 1);
        check("a_wdat", rf_wd, 32'hDEADBEEF);
        check("a_rdidx", rf_ri, 5);
        check("a_grant", grant, 3'b001);
        adv();
        @(negedge clk);
        check("a_one_write", rf_ena, 0);
        check("a_grant_clr", grant, 0);
        adv();

        // Starvation guard: 7x ch1, ch0, 7x ch1, ch2, ...
        do_reset();
        keep = 3'b111;
        for (int i = 0; i < NCH; i++) new_pld(i);
        vld = 3'b111;
        repeat (32) tick();
        vld = '0;
        flush("b_drain");
        check("b_count", gq.size(), 32);
        for (int k = 0; k < 32 && k < gq.size(); k++) begin
            int p, e;
            p = k % 16;
            e = (p == 7) ? 0 : (p == 15) ? 2 : 1;
            check("b_grant", gq[k], e);
        end

        // Low-class alternation with pointer wrap
        do_reset();
        keep = 3'b101;
        new_pld(0);
        new_pld(2);
        vld = 3'b101;
        repeat (8) tick();
        vld = '0;
        flush("c_drain");
        check("c_count", gq.size(), 8);
        for (int k = 0; k < 8 && k < gq.size(); k++)
            check("c_grant", gq[k], (k % 2 == 1) ? 2 : 0);

        // Backpressure holds the stage
        do_reset();
        new_pld(0);
        hold_a = wd[0];
        vld = 3'b001;
        tick();
        rf_rdy = 1'b0;
        new_pld(2);
        hold_b = wd[2];
        vld[2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("d_ena", rf_ena, 1);
            check("d_wdat", rf_wd, hold_a);
            check("d_ready", rdy, 0);
            adv();
        end
        rf_rdy = 1'b1;
        @(negedge clk);
        check("d_rel_ready", rdy, 3'b100);
        check("d_rel_wdat", rf_wd, hold_a);
        adv();
        @(negedge clk);
        check("d_next_wdat", rf_wd, hold_b);
        adv();
        flush("d_drain");

        // FP-destined entry
        do_reset();
        fpv[0] = 1'b1;
        fl[0]  = 5'b10001;
        new_pld(0);
        new_pld(2);
        vld    = 3'b101;
        rf_rdy = 1'b0;
        @(negedge clk);
        check("e_ready0", rdy, 3'b001);
        adv();
        @(negedge clk);
        check("e_rf_ena", rf_ena, 0);
`ifdef E203_WBCK_FPU_EN
        check("e_frf_ena", frf_ena, 1);
        check("e_frf_flags", frf_fl, 5'b10001);
`endif
        check("e_ready2", rdy, 3'b100);
        adv();
        fpv[0] = 1'b0;
        @(negedge clk);
        check("e_rf_ena2", rf_ena, 1);
        adv();
        rf_rdy = 1'b1;
        flush("e_drain");

        // Reset with an entry held
        do_reset();
        keep = 3'b111;
        for (int i = 0; i < NCH; i++) new_pld(i);
        vld = 3'b111;
        repeat (10) tick();
        vld  = '0;
        keep = '0;
        check("f_starve_pre", dut.starve_q, 2);
        @(negedge clk);
        check("f_ena_pre", rf_ena, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_ena_rst", rf_ena, 0);
        check("f_grant_rst", grant, 0);
        check("f_wdat_rst", rf_wd, 0);
        sb.delete();
        gq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("f_ptr", dut.u_lo_arb.ptr_q, 0);
        check("f_starve", dut.starve_q, 0);
        repeat (2) tick();
        check("f_no_write", rf_ena, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
